// File: rtl/z80_io_if.sv
// Bundle of the Wishbone slave port and the Z80 I/O pin group of z80_io_initiator.
// Wishbone handshake: a request is valid when wb_cyc_in & wb_stb_in are high; the slave never stalls
// and answers a decoded address with wb_ack_out (and wb_data_out) exactly one cycle later.
interface z80_io_if;
   logic        wb_cyc_in;
   logic        wb_stb_in;
   logic        wb_we_in;
   logic [31:0] wb_addr_in;
   logic [31:0] wb_data_in;
   logic        wb_ack_out;
   logic        wb_stall_out;
   logic [31:0] wb_data_out;
   logic        irq_done_out;
   logic [7:0]  z80_address_bus;
   logic [7:0]  z80_data_bus_out;
   logic [7:0]  z80_data_bus_in;
   logic        z80_bus_dir;
   logic        z80_write_strobe_b;
   logic        z80_read_strobe_b;

   modport slave (
      input  wb_cyc_in, wb_stb_in, wb_we_in, wb_addr_in, wb_data_in, z80_data_bus_in,
      output wb_ack_out, wb_stall_out, wb_data_out, irq_done_out,
             z80_address_bus, z80_data_bus_out, z80_bus_dir,
             z80_write_strobe_b, z80_read_strobe_b
   );

   modport master (
      output wb_cyc_in, wb_stb_in, wb_we_in, wb_addr_in, wb_data_in, z80_data_bus_in,
      input  wb_ack_out, wb_stall_out, wb_data_out, irq_done_out,
             z80_address_bus, z80_data_bus_out, z80_bus_dir,
             z80_write_strobe_b, z80_read_strobe_b
   );
endinterface

// File: rtl/z80_io_initiator.sv
// Wishbone-controlled Z80 I/O cycle generator: programmable setup/strobe/hold phases,
// read-data capture, done/overrun status and a level completion IRQ.
module z80_io_initiator #(
   parameter logic [31:0] BASE_ADDRESS = 32'h3000_0100
) (
   input  logic       clk,
   input  logic       reset,
   z80_io_if.slave    bus,
   output logic [1:0] state_o
);
   localparam logic [31:0] CMD_ADDRESS    = BASE_ADDRESS;
   localparam logic [31:0] STATUS_ADDRESS = BASE_ADDRESS + 32'd4;
   localparam logic [31:0] TIMING_ADDRESS = BASE_ADDRESS + 32'd8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  t_len_q, t_len_d, h_len_q, h_len_d;
   logic [7:0]  addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic        dir_q, dir_d, done_q, done_d, ovr_q, ovr_d, ack_q, ack_d;
   logic [11:0] timing_q, timing_d;
   logic [31:0] rdat_q, rdat_d;

   logic wb_access, hit_cmd, hit_status, hit_timing, hit_any;
   logic cmd_wr, status_rd, timing_wr, busy, accept, complete;
   logic unused_wb_data;

   // A programmed phase length of zero still occupies one cycle.
   function automatic logic [3:0] phase_len(input logic [3:0] f);
      return (f == 4'd0) ? 4'd1 : f;
   endfunction

   always_comb begin
      wb_access  = bus.wb_cyc_in & bus.wb_stb_in;
      hit_cmd    = wb_access && (bus.wb_addr_in == CMD_ADDRESS);
      hit_status = wb_access && (bus.wb_addr_in == STATUS_ADDRESS);
      hit_timing = wb_access && (bus.wb_addr_in == TIMING_ADDRESS);
      hit_any    = hit_cmd | hit_status | hit_timing;
      cmd_wr     = hit_cmd & bus.wb_we_in;
      status_rd  = hit_status & ~bus.wb_we_in;
      timing_wr  = hit_timing & bus.wb_we_in;
      busy       = (state_q != ST_IDLE);
      accept     = cmd_wr & ~busy;
      complete   = (state_q == ST_HOLD) && (cnt_q == 4'd0);

      state_d  = state_q;
      cnt_d    = cnt_q;
      t_len_d  = t_len_q;
      h_len_d  = h_len_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      dir_d    = dir_q;
      rdata_d  = rdata_q;
      timing_d = timing_q;
      done_d   = done_q;
      ovr_d    = ovr_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_SETUP;
               cnt_d   = phase_len(timing_q[3:0]) - 4'd1;
               t_len_d = phase_len(timing_q[7:4]);
               h_len_d = phase_len(timing_q[11:8]);
               addr_d  = bus.wb_data_in[7:0];
               wdata_d = bus.wb_data_in[15:8];
               dir_d   = bus.wb_data_in[16];
            end
         end
         ST_SETUP: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_STROBE;
               cnt_d   = t_len_q - 4'd1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_STROBE: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_HOLD;
               cnt_d   = h_len_q - 4'd1;
               if (!dir_q) rdata_d = bus.z80_data_bus_in;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == 4'd0) state_d = ST_IDLE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         default: state_d = ST_IDLE;
      endcase

      // Flags set on the same edge as a STATUS read keep their set value.
      if (status_rd) begin
         done_d = 1'b0;
         ovr_d  = 1'b0;
      end
      if (complete)      done_d = 1'b1;
      if (cmd_wr & busy) ovr_d  = 1'b1;
      if (timing_wr)     timing_d = bus.wb_data_in[11:0];

      ack_d  = hit_any;
      rdat_d = 32'd0;
      if (hit_any && !bus.wb_we_in) begin
         if (hit_status)      rdat_d = {16'd0, rdata_q, 5'd0, ovr_q, done_q, busy};
         else if (hit_timing) rdat_d = {20'd0, timing_q};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         t_len_q  <= 4'd1;
         h_len_q  <= 4'd1;
         addr_q   <= 8'd0;
         wdata_q  <= 8'd0;
         dir_q    <= 1'b0;
         rdata_q  <= 8'd0;
         timing_q <= 12'h242;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
         ack_q    <= 1'b0;
         rdat_q   <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         t_len_q  <= t_len_d;
         h_len_q  <= h_len_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         dir_q    <= dir_d;
         rdata_q  <= rdata_d;
         timing_q <= timing_d;
         done_q   <= done_d;
         ovr_q    <= ovr_d;
         ack_q    <= ack_d;
         rdat_q   <= rdat_d;
      end
   end

   assign bus.wb_ack_out         = ack_q;
   assign bus.wb_stall_out       = 1'b0;
   assign bus.wb_data_out        = rdat_q;
   assign bus.irq_done_out       = done_q;
   assign bus.z80_address_bus    = addr_q;
   assign bus.z80_data_bus_out   = wdata_q;
   assign bus.z80_bus_dir        = (state_q != ST_IDLE) & dir_q;
   assign bus.z80_write_strobe_b = ~((state_q == ST_STROBE) & dir_q);
   assign bus.z80_read_strobe_b  = ~((state_q == ST_STROBE) & ~dir_q);
   assign state_o                = state_q;
   assign unused_wb_data         = ^bus.wb_data_in[31:17];
endmodule

// File: doc/z80_io_initiator.md
# z80_io_initiator

Wishbone-controlled Z80 I/O bus initiator. It generates Z80-style I/O write and read cycles (address, data, active-low strobes) with programmable setup, strobe and hold widths. The SoC uses it to drive an external Z80 I/O peripheral, or a second zube-style mailbox, from the SoC side. It sits on the same Wishbone bus and clock as the other peripherals and talks to external pins through a bus transceiver.

## Interface
- BASE_ADDRESS, 32'h3000_0100: Wishbone base address.
- CMD_ADDRESS, BASE_ADDRESS: command register (write-only; reads return 0).
- STATUS_ADDRESS, BASE_ADDRESS + 4: status/read-data register.
- TIMING_ADDRESS, BASE_ADDRESS + 8: cycle timing register.

Ports:
- clk  in  1  high-speed Wishbone clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- wb_cyc_in, wb_stb_in, wb_we_in  in  1 each  Wishbone cycle, strobe, write-enable.
- wb_addr_in  in  32  Wishbone address.
- wb_data_in  in  32  Wishbone write data.
- wb_ack_out  out  1  acknowledge.
- wb_stall_out  out  1  tied to 0.
- wb_data_out  out  32  read data.
- irq_done_out  out  1  level IRQ; set when a transaction completes, cleared by a STATUS read.
- z80_address_bus  out  8  I/O address.
- z80_data_bus_out  out  8  write data to the transceiver.
- z80_data_bus_in  in  8  read data from the transceiver.
- z80_bus_dir  out  1  high while this block drives the data bus.
- z80_write_strobe_b  out  1  active-low write strobe.
- z80_read_strobe_b  out  1  active-low read strobe.

## Operation
- CMD write:
  - Fields: [7:0] address, [15:8] write data, [16] dir (1 = write, 0 = read).
  - Accepted only when state is IDLE.
  - If busy, the write is dropped and the sticky overrun flag is set.
- STATUS read:
  - Fields: [0] busy, [1] done, [2] overrun, [15:8] last read data; other bits 0.
  - Clears done, overrun and irq_done_out.
- TIMING register:
  - Fields: [3:0] setup S, [7:4] strobe T, [11:8] hold H. Reset value 12'h242.
  - A field value of 0 is treated as 1.
  - Read back returns the raw stored value.
  - S/T/H are latched at command acceptance. A TIMING write during a transaction affects only the next transaction.
- FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE -> SETUP on command accept.
  - SETUP -> STROBE after S cycles.
  - STROBE -> HOLD after T cycles.
  - HOLD -> IDLE after H cycles.
  - One down-counter (4 bits) is reloaded at each transition.
- Address and write data are latched at command accept and held on the pins from SETUP through HOLD. In IDLE they keep their last values.
- z80_bus_dir is 1 in SETUP, STROBE and HOLD of a write; 0 otherwise.
- Strobe assertion: z80_write_strobe_b (write) or z80_read_strobe_b (read) is 0 only in STROBE. Both strobes are never low together.
- Read capture: on the clock edge leaving STROBE, z80_data_bus_in is registered into the read-data field.
- Completion: on the edge HOLD -> IDLE, done and irq_done_out are set to 1.
- Wishbone:
  - wb_ack_out is 1 the cycle after stb&cyc when the address matches any of the three registers; 0 otherwise.
  - wb_data_out is registered on the same edge.
  - Unmatched addresses get no ack.

## Timing
- Reset values (one cycle after reset sampled high):
  - state IDLE.
  - z80_write_strobe_b = z80_read_strobe_b = 1.
  - z80_bus_dir = 0.
  - z80_address_bus = 0, z80_data_bus_out = 0.
  - wb_ack_out = 0, wb_data_out = 0.
  - irq_done_out = 0.
  - done, overrun, read data = 0.
  - TIMING = 12'h242.
- Latency:
  - CMD accepted at edge E; pins show SETUP values after E.
  - Strobe low after E+S for exactly T cycles, then HOLD for H cycles.
  - busy reads 1 for S+T+H cycles; done is visible after E+S+T+H.
- busy is evaluated at the accepting edge. A CMD write on the same edge as HOLD -> IDLE counts as overrun and is dropped.
- STATUS read on the same edge that done/irq sets: set wins, so done and irq stay 1. The returned value shows the pre-edge state.
- Reset mid-transaction: next edge forces IDLE, strobes high and bus_dir 0. No done is raised and no read data is captured.
- Counter arithmetic is 4-bit; the maximum per phase is 15 cycles; no wrap.

## Test plan
- Default write: TIMING reset, CMD = 0x1_5A80 -> address 0x80 and data 0x5A for 8 cycles; bus_dir high for 8 cycles; write strobe low exactly cycles 3–6; done=1 and irq=1 after cycle 8; read strobe stays high.
- Read: z80_data_bus_in = 0xC3 during strobe, CMD = 0x0_0081 -> read strobe low 4 cycles; bus_dir 0 throughout; STATUS = 0x0000_C302; a second STATUS read returns 0x0000_C300 and irq=0.
- Overrun: second CMD issued 2 cycles after the first -> only the first transaction appears on the pins; STATUS bit2=1; bit2 clears after the read.
- Timing fields: TIMING = 0x000 -> 1/1/1 cycle phases, total busy 3 cycles; TIMING = 0xF1F -> strobe phase of 1 cycle between setup and hold phases of 15 cycles each.
- Reset mid-STROBE: assert reset in cycle 4 of a write -> strobes high and bus_dir 0 the next cycle; STATUS = 0 after reset.
- Collision: STATUS read on the completion edge -> returned done=0 and busy=1; the following STATUS read returns done=1.
